// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared scan-code constants, decoder state type and ASCII lookup
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_DEC  = 2'd2
    } dec_state_t;

    // Set-2 scan code to lowercase ASCII; unmapped codes give 0x00.
    function automatic logic [7:0] sc2ascii(input logic [7:0] sc);
        logic [7:0] a;
        a = 8'h00;
        case (sc)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - receiver FIFO side and key event side of the decoder
interface ps2_key_decoder_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       ps2_byte;
    logic             ps2_ready;
    logic             ps2_overflow;
    logic             ps2_nextdata_n;
    logic             key_valid;
    logic             key_make;
    logic             key_ext;
    logic             key_repeat;
    logic [7:0]       key_code;
    logic [7:0]       key_ascii;
    logic             key_held;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_seen;

    modport master (
        output ps2_byte, ps2_ready, ps2_overflow,
        input  ps2_nextdata_n, key_valid, key_make, key_ext, key_repeat,
               key_code, key_ascii, key_held, press_cnt, ovf_seen
    );

    modport slave (
        input  ps2_byte, ps2_ready, ps2_overflow,
        output ps2_nextdata_n, key_valid, key_make, key_ext, key_repeat,
               key_code, key_ascii, key_held, press_cnt, ovf_seen
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - turns PS/2 Set-2 scan-code bytes into registered key events
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    ps2_key_decoder_if.slave    bus
);

    dec_state_t       state_q;
    logic [7:0]       byte_q;
    logic             ext_pend;
    logic             brk_pend;
    logic             held_ext;
    logic [7:0]       held_code;
    logic [CNT_W-1:0] cnt_q;
    logic             held_match;

    assign bus.press_cnt = cnt_q;
    assign held_match    = (held_ext == ext_pend) && (held_code == byte_q);

    // Pop one byte per pass (idle -> pop -> decode) and update event, held and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            byte_q             <= 8'h00;
            ext_pend           <= 1'b0;
            brk_pend           <= 1'b0;
            held_ext           <= 1'b0;
            held_code          <= 8'h00;
            cnt_q              <= '0;
            bus.ps2_nextdata_n <= 1'b1;
            bus.key_valid      <= 1'b0;
            bus.key_make       <= 1'b0;
            bus.key_ext        <= 1'b0;
            bus.key_repeat     <= 1'b0;
            bus.key_code       <= 8'h00;
            bus.key_ascii      <= 8'h00;
            bus.key_held       <= 1'b0;
            bus.ovf_seen       <= 1'b0;
        end else begin
            bus.key_valid <= 1'b0;
            if (bus.ps2_overflow) begin
                bus.ovf_seen <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.ps2_ready) begin
                        byte_q             <= bus.ps2_byte;
                        bus.ps2_nextdata_n <= 1'b0;
                        state_q            <= S_POP;
                    end
                end
                S_POP: begin
                    bus.ps2_nextdata_n <= 1'b1;
                    state_q            <= S_DEC;
                end
                S_DEC: begin
                    state_q <= S_IDLE;
                    if (byte_q == SC_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_q == SC_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        bus.key_valid <= 1'b1;
                        bus.key_make  <= ~brk_pend;
                        bus.key_ext   <= ext_pend;
                        bus.key_code  <= byte_q;
                        bus.key_ascii <= ext_pend ? 8'h00 : sc2ascii(byte_q);
                        ext_pend      <= 1'b0;
                        brk_pend      <= 1'b0;
                        if (!brk_pend) begin
                            // Same key still down means typematic repeat; anything else is a new press.
                            if (bus.key_held && held_match) begin
                                bus.key_repeat <= 1'b1;
                            end else begin
                                bus.key_repeat <= 1'b0;
                                held_ext       <= ext_pend;
                                held_code      <= byte_q;
                                bus.key_held   <= 1'b1;
                                cnt_q          <= cnt_q + 1'b1;
                            end
                        end else begin
                            bus.key_repeat <= 1'b0;
                            if (held_match) begin
                                bus.key_held <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    typedef struct packed {
        logic       make;
        logic       ext;
        logic       rpt;
        logic [7:0] code;
        logic [7:0] ascii;
        logic       held;
        logic [7:0] cnt;
    } ev_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    ps2_key_decoder_if #(.CNT_W(8)) bus ();
    ps2_key_decoder #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] fifo[$];
    ev_t        obs[$];
    ev_t        exp_q[$];
    int         pop_cyc[$];
    int         val_cyc[$];

    logic [7:0] asc_tab[256];
    bit         m_ext, m_brk, m_held;
    logic [8:0] m_key;
    int         m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiver FIFO model: the head advances on an edge where the pop strobe is low.
    always @(posedge clk) begin
        bit pop_now;
        cyc++;
        pop_now = (bus.ps2_nextdata_n === 1'b0);
        #1;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        bus.ps2_ready = (fifo.size() != 0);
        bus.ps2_byte  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // Capture pop strobes and completed events mid-cycle.
    always @(negedge clk) begin
        if (bus.ps2_nextdata_n === 1'b0) pop_cyc.push_back(cyc);
        if (bus.key_valid === 1'b1) begin
            obs.push_back('{bus.key_make, bus.key_ext, bus.key_repeat, bus.key_code,
                            bus.key_ascii, bus.key_held, bus.press_cnt});
            val_cyc.push_back(cyc);
        end
    end

    function automatic void model_feed(input logic [7:0] b);
        ev_t e;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            e.make  = !m_brk;
            e.ext   = m_ext;
            e.code  = b;
            e.ascii = m_ext ? 8'h00 : asc_tab[b];
            e.rpt   = 1'b0;
            if (e.make) begin
                if (m_held && m_key == {m_ext, b}) e.rpt = 1'b1;
                else begin
                    m_key  = {m_ext, b};
                    m_held = 1'b1;
                    m_cnt  = (m_cnt + 1) % 256;
                end
            end else if (m_key == {m_ext, b}) begin
                m_held = 1'b0;
            end
            e.held = m_held;
            e.cnt  = m_cnt[7:0];
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        fifo.push_back(b);
        bus.ps2_ready = 1'b1;
        bus.ps2_byte  = fifo[0];
        model_feed(b);
        repeat (gap) tick();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (fifo.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        repeat (6) tick();
        tests++;
        if (fifo.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d bytes left, required 0", fifo.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo.delete();
        bus.ps2_ready = 1'b0;
        bus.ps2_byte  = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        m_ext = 0; m_brk = 0; m_held = 0; m_key = '0; m_cnt = 0;
        obs.delete(); exp_q.delete(); pop_cyc.delete(); val_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.ps2_nextdata_n !== 1'b1) begin
            fails++; $display("FAIL reset_nextdata_n: got %b required 1", bus.ps2_nextdata_n);
        end
        tests++;
        if ({bus.key_valid, bus.key_make, bus.key_ext, bus.key_repeat, bus.key_held, bus.ovf_seen} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b required 000000",
                {bus.key_valid, bus.key_make, bus.key_ext, bus.key_repeat, bus.key_held, bus.ovf_seen});
        end
        tests++;
        if ({bus.key_code, bus.key_ascii, bus.press_cnt} !== 24'h0) begin
            fails++; $display("FAIL reset_fields: got %h required 000000", {bus.key_code, bus.key_ascii, bus.press_cnt});
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h1C, 4); send(8'hF0, 2); send(8'h1C, 0);
        drain(100);
        tests++;
        if (obs.size() != exp_q.size()) begin
            fails++; $display("FAIL make_break_count: got %0d required %0d", obs.size(), exp_q.size());
        end else for (int i = 0; i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL make_break_ev%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        tests++;
        if (obs.size() < 1 || obs[0].ascii !== 8'h61 || obs[0].cnt !== 8'd1) begin
            fails++; $display("FAIL make_break_a: got %0d events, required ascii 61 cnt 1", obs.size());
        end
    endtask

    task automatic test_sequences();
        logic [7:0] seqs[3][] = '{
            '{8'h15, 8'h15, 8'h15, 8'hF0, 8'h15},
            '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75},
            '{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32}};
        for (int s = 0; s < 3; s++) begin
            do_reset();
            foreach (seqs[s][k]) send(seqs[s][k], s);
            drain(200);
            tests++;
            if (obs.size() != exp_q.size()) begin
                fails++; $display("FAIL seq%0d_count: got %0d required %0d", s, obs.size(), exp_q.size());
            end else for (int i = 0; i < obs.size(); i++) begin
                tests++;
                if (obs[i] !== exp_q[i]) begin
                    fails++; $display("FAIL seq%0d_ev%0d: got %h required %h", s, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h23, 8'h29, 8'h5A, 8'h66};
        do_reset();
        for (int i = 0; i < 80; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            send(b, $urandom_range(0, 6));
        end
        drain(600);
        tests++;
        if (obs.size() != exp_q.size()) begin
            fails++; $display("FAIL random_count: got %0d required %0d", obs.size(), exp_q.size());
        end else for (int i = 0; i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL random_ev%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            bit x;
            c = 8'(i);
            x = (c == 8'hE0) || (c == 8'hF0);
            if (x) c = (c == 8'hE0) ? 8'h01 : 8'h02;
            if (x) send(8'hE0, 0);
            send(c, 0);
            if (x) send(8'hE0, 0);
            send(8'hF0, 0);
            send(c, 0);
        end
        drain(5000);
        tests++;
        if (obs.size() != exp_q.size()) begin
            fails++; $display("FAIL wrap_count: got %0d required %0d", obs.size(), exp_q.size());
        end else for (int i = 0; i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL wrap_ev%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        tests++;
        if (bus.press_cnt !== 8'd0) begin
            fails++; $display("FAIL wrap_cnt: got %0d required 0", bus.press_cnt);
        end
    endtask

    task automatic test_pop_timing();
        do_reset();
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        drain(100);
        tests++;
        if (pop_cyc.size() != 3) begin
            fails++; $display("FAIL pop_count: got %0d required 3", pop_cyc.size());
        end else begin
            tests++;
            if (pop_cyc[1] - pop_cyc[0] != 3 || pop_cyc[2] - pop_cyc[1] != 3) begin
                fails++; $display("FAIL pop_spacing: got %0d,%0d required 3,3",
                    pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            end
            tests++;
            if (val_cyc.size() != 2 || val_cyc[0] != pop_cyc[0] + 2 || val_cyc[1] != pop_cyc[2] + 2) begin
                fails++; $display("FAIL valid_latency: got %0d events, required valid 2 cycles after pop", val_cyc.size());
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send(8'hF0, 0);
        drain(50);
        do_reset();
        send(8'h23, 0);
        drain(50);
        tests++;
        if (obs.size() != 1 || obs[0].make !== 1'b1 || obs[0].code !== 8'h23 || obs[0].ascii !== 8'h64) begin
            fails++; $display("FAIL rst_mid: got %0d events first %h, required one make 23 ascii 64",
                obs.size(), (obs.size() > 0) ? obs[0] : '0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.ps2_overflow = 1'b1;
        tick();
        bus.ps2_overflow = 1'b0;
        repeat (5) tick();
        tests++;
        if (bus.ovf_seen !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky: got %b required 1", bus.ovf_seen);
        end
        do_reset();
        tests++;
        if (bus.ovf_seen !== 1'b0) begin
            fails++; $display("FAIL ovf_clear: got %b required 0", bus.ovf_seen);
        end
    endtask

    initial begin
        logic [7:0] let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 256; i++) asc_tab[i] = 8'h00;
        for (int i = 0; i < 26; i++) asc_tab[let_sc[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) asc_tab[dig_sc[i]] = 8'h30 + 8'(i);
        asc_tab[8'h29] = 8'h20;
        asc_tab[8'h5A] = 8'h0D;
        asc_tab[8'h66] = 8'h08;
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1;
        bus.ps2_byte = 8'h00; bus.ps2_ready = 1'b0; bus.ps2_overflow = 1'b0;
        test_reset();
        test_make_break();
        test_sequences();
        test_random();
        test_wrap();
        test_pop_timing();
        test_rst_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes raw PS/2 Set-2 scan-code bytes from the `ps2_keyboard` receiver FIFO and turns them into key events. Each event carries make/break, extended, repeat, code, ASCII and held status. It replaces the ad-hoc F0 tracking in the top level and feeds the seven-segment, LED and character-display logic downstream.

## Interface
Parameters:
- `CNT_W`, default 8: width of `press_cnt`.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk` in 1: system clock, shared with `ps2_keyboard`.
- `rst` in 1: synchronous active-high reset.
- `ps2_byte` in 8: FIFO head byte (`ps2_keyboard.data`).
- `ps2_ready` in 1: FIFO non-empty.
- `ps2_overflow` in 1: FIFO overflow flag.
- `ps2_nextdata_n` out 1: active-low pop strobe, registered.
- `key_valid` out 1: one-cycle pulse when an event is complete.
- `key_make` out 1: 1 = press, 0 = release.
- `key_ext` out 1: event was E0-prefixed.
- `key_repeat` out 1: make event is a typematic repeat.
- `key_code` out 8: final scan-code byte of the event.
- `key_ascii` out 8: lowercase ASCII; 0x00 if unmapped or extended.
- `key_held` out 1: a key is currently held down.
- `press_cnt` out `CNT_W`: count of non-repeat make events.
- `ovf_seen` out 1: sticky; set when `ps2_overflow` is 1.

## Operation
- FSM states: S_IDLE, S_POP, S_DEC.
  - S_IDLE with `ps2_ready`=1: latch `ps2_byte` into `byte_q`, set `ps2_nextdata_n`<=0, go to S_POP.
  - S_IDLE otherwise: stay.
  - S_POP: `ps2_nextdata_n`<=1, go to S_DEC. The FIFO advances on this edge.
  - S_DEC: decode `byte_q`, go to S_IDLE.
- Decode rules, applied in S_DEC:
  - `byte_q`=E0: set `ext_pend`; no event.
  - `byte_q`=F0: set `brk_pend`; no event.
  - Any other byte: emit an event with `key_make`=~`brk_pend`, `key_ext`=`ext_pend`, `key_code`=`byte_q`. Then clear both pending flags.
- Held tracking (single key, last-make-wins):
  - Make while `key_held`=1 with the same {ext,code} as the held key: `key_repeat`=1, `press_cnt` unchanged.
  - Any other make: `key_repeat`=0, store {ext,code} as the held key, `key_held`<=1, `press_cnt`+1.
  - Break matching the held key: `key_held`<=0.
  - Break for a different key: no change to `key_held`.
  - `key_repeat`=0 on all breaks.
- `press_cnt` wraps from 2^`CNT_W`-1 to 0.
- ASCII mapping applies to non-extended events only, on both make and break:
  - Letters 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - 29 space (0x20), 5A Enter (0x0D), 66 Backspace (0x08).
  - All other codes map to 0x00.
- `ovf_seen` sets when `ps2_overflow`=1 and clears only on `rst`.

## Timing
- Reset values:
  - `ps2_nextdata_n`=1.
  - `key_valid`, `key_make`, `key_ext`, `key_repeat`, `key_held`, `ovf_seen` = 0.
  - `key_code`, `key_ascii`, `press_cnt` = 0.
  - State S_IDLE; pending flags cleared.
- All outputs are registered.
- Per byte, with `ps2_ready` first sampled 1 at edge E:
  - `ps2_nextdata_n`=0 for exactly the cycle after E.
  - `key_valid`=1 for the cycle after E+2.
  - S_IDLE samples `ps2_ready` again at E+3.
- Throughput is 1 byte per 3 cycles. This far exceeds the PS/2 rate, so the FIFO never backs up under normal operation.
- Exactly one pop per byte. `ps2_ready` is ignored outside S_IDLE.
- Event fields hold their values after `key_valid` drops, until the next event.
- Prefixes split across arbitrary idle gaps decode identically to back-to-back bytes.
- Reset mid-sequence (for example after F0, before the code byte): pending flags are cleared; the next code byte decodes as a make.
- E0 and F0 are both pending when the code byte arrives: `key_ext`=1, `key_make`=0.

## Structure
- Package `ps2_pkg`:
  - Constants `SC_EXT`=8'hE0, `SC_BRK`=8'hF0.
  - Enum `dec_state_t`.
  - Function `sc2ascii(input [7:0])`, reusable by the display path.
- No sub-module; ASCII lookup is a combinational case registered into `key_ascii`.

## Test plan
- Bytes 1C, F0, 1C: first event `key_valid`, make, code 1C, ascii 0x61, held=1, cnt=1. Second event break, ascii 0x61, held=0, cnt=1.
- Bytes 15, 15, 15, F0, 15: three makes with repeat=0,1,1; cnt=1; final break clears held.
- Bytes E0, 75, E0, F0, 75: make ext=1 code 75 ascii 0x00; then break ext=1; held returns to 0.
- Bytes 1C, 32, F0, 1C: second make replaces the held key (cnt=2). Break 1C leaves held=1. Then F0, 32 clears it.
- 256 distinct make/break pairs with `CNT_W`=8: `press_cnt` wraps to 0.
- `ps2_ready` forced high for 3 bytes: `ps2_nextdata_n` low exactly once per byte, 3 cycles apart.
- `rst` asserted after F0: the following 23 decodes as make code 23, ascii 0x64.
- `ps2_overflow` pulsed: `ovf_seen`=1 until `rst`.
